// File: rtl/decode_pkg.sv
// Shared encodings and the decoded-entry record for the decode stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package decode_pkg;

    localparam logic [10:0] ALU_NONE   = 11'd0;
    localparam logic [10:0] ALU_ADD    = 11'd1;
    localparam logic [10:0] ALU_SUB    = 11'd2;
    localparam logic [10:0] ALU_SLL    = 11'd3;
    localparam logic [10:0] ALU_SLT    = 11'd4;
    localparam logic [10:0] ALU_SLTU   = 11'd5;
    localparam logic [10:0] ALU_XOR    = 11'd6;
    localparam logic [10:0] ALU_SRL    = 11'd7;
    localparam logic [10:0] ALU_SRA    = 11'd8;
    localparam logic [10:0] ALU_OR     = 11'd9;
    localparam logic [10:0] ALU_AND    = 11'd10;
    localparam logic [10:0] ALU_MUL    = 11'd11;
    localparam logic [10:0] ALU_MULH   = 11'd12;
    localparam logic [10:0] ALU_MULHSU = 11'd13;
    localparam logic [10:0] ALU_MULHU  = 11'd14;
    localparam logic [10:0] ALU_DIV    = 11'd15;
    localparam logic [10:0] ALU_DIVU   = 11'd16;
    localparam logic [10:0] ALU_REM    = 11'd17;
    localparam logic [10:0] ALU_REMU   = 11'd18;
    localparam logic [10:0] ALU_BEQ    = 11'd19;
    localparam logic [10:0] ALU_BNE    = 11'd20;
    localparam logic [10:0] ALU_BLT    = 11'd21;
    localparam logic [10:0] ALU_BGE    = 11'd22;
    localparam logic [10:0] ALU_BLTU   = 11'd23;
    localparam logic [10:0] ALU_BGEU   = 11'd24;
    localparam logic [10:0] ALU_LUI    = 11'd25;
    // OR-ed onto a base op to mark the 32-bit "W" variant on RV64
    localparam logic [10:0] ALU_WORD   = 11'h400;

    localparam logic [3:0] IT_NONE = 4'd0;
    localparam logic [3:0] IT_R    = 4'd1;
    localparam logic [3:0] IT_I    = 4'd2;
    localparam logic [3:0] IT_S    = 4'd3;
    localparam logic [3:0] IT_SB   = 4'd4;
    localparam logic [3:0] IT_U    = 4'd5;
    localparam logic [3:0] IT_UJ   = 4'd6;

    localparam logic [1:0] MA_NONE  = 2'd0;
    localparam logic [1:0] MA_READ  = 2'd1;
    localparam logic [1:0] MA_WRITE = 2'd2;

    localparam logic [2:0] MS_NONE = 3'd0;
    localparam logic [2:0] MS_B    = 3'd1;
    localparam logic [2:0] MS_H    = 3'd2;
    localparam logic [2:0] MS_W    = 3'd3;
    localparam logic [2:0] MS_D    = 3'd4;
    localparam logic [2:0] MS_BU   = 3'd5;
    localparam logic [2:0] MS_HU   = 3'd6;
    localparam logic [2:0] MS_WU   = 3'd7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    // Fields are sized for the widest datapath; narrower configs use the low bits.
    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [10:0] alu_op;
        logic [5:0]  shamt;
        logic        reg_write;
        logic [3:0]  instr_type;
        logic [1:0]  mem_access;
        logic [2:0]  mem_size;
        logic        illegal;
    } entry_t;

    function automatic logic [10:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

    function automatic logic [10:0] alu_mul(input logic [2:0] f3);
        alu_mul = ALU_MUL + {8'd0, f3};
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32/RV64 (+M) instruction decoder producing one entry_t.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller decides when the result is captured.
module decode_logic
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int HAS_M = 1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output entry_t          entry
);

    localparam bit RV64 = (XLEN == 64);
    localparam bit M_OK = (HAS_M != 0);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("decode_logic: XLEN must be 32 or 64");
    end

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    entry_t      d;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{52{instr[31]}}, instr[31:20]};
    assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'd0};
    assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        d     = '0;
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                legal        = 1'b1;
                d.instr_type = IT_U;
                d.imm        = imm_u;
                d.rd         = instr[11:7];
                d.reg_write  = 1'b1;
                d.alu_op     = (opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
            end
            OP_JAL: begin
                legal        = 1'b1;
                d.instr_type = IT_UJ;
                d.imm        = imm_j;
                d.rd         = instr[11:7];
                d.reg_write  = 1'b1;
                d.alu_op     = ALU_ADD;
            end
            OP_JALR: begin
                legal        = (f3 == 3'b000);
                d.instr_type = IT_I;
                d.imm        = imm_i;
                d.rd         = instr[11:7];
                d.rs1        = instr[19:15];
                d.reg_write  = 1'b1;
                d.alu_op     = ALU_ADD;
            end
            OP_BRANCH: begin
                legal        = (f3 != 3'b010) && (f3 != 3'b011);
                d.instr_type = IT_SB;
                d.imm        = imm_b;
                d.rs1        = instr[19:15];
                d.rs2        = instr[24:20];
                case (f3)
                    3'b000:  d.alu_op = ALU_BEQ;
                    3'b001:  d.alu_op = ALU_BNE;
                    3'b100:  d.alu_op = ALU_BLT;
                    3'b101:  d.alu_op = ALU_BGE;
                    3'b110:  d.alu_op = ALU_BLTU;
                    default: d.alu_op = ALU_BGEU;
                endcase
            end
            OP_LOAD: begin
                legal        = (f3 != 3'b111) && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
                d.instr_type = IT_I;
                d.imm        = imm_i;
                d.rd         = instr[11:7];
                d.rs1        = instr[19:15];
                d.reg_write  = 1'b1;
                d.alu_op     = ALU_ADD;
                d.mem_access = MA_READ;
                case (f3)
                    3'b000:  d.mem_size = MS_B;
                    3'b001:  d.mem_size = MS_H;
                    3'b010:  d.mem_size = MS_W;
                    3'b011:  d.mem_size = MS_D;
                    3'b100:  d.mem_size = MS_BU;
                    3'b101:  d.mem_size = MS_HU;
                    default: d.mem_size = MS_WU;
                endcase
            end
            OP_STORE: begin
                legal        = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                               (RV64 && f3 == 3'b011);
                d.instr_type = IT_S;
                d.imm        = imm_s;
                d.rs1        = instr[19:15];
                d.rs2        = instr[24:20];
                d.alu_op     = ALU_ADD;
                d.mem_access = MA_WRITE;
                d.mem_size   = MS_B + f3[1:0];
            end
            OP_IMM: begin
                d.instr_type = IT_I;
                d.rd         = instr[11:7];
                d.rs1        = instr[19:15];
                d.reg_write  = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // shamt[5] only exists on RV64
                    legal   = (instr[31:26] == 6'b000000 ||
                               (f3 == 3'b101 && instr[31:26] == 6'b010000)) &&
                              (RV64 || !instr[25]);
                    d.shamt = instr[25:20];
                    d.imm   = {58'd0, instr[25:20]};
                    d.alu_op = alu_base(f3, instr[30]);
                end else begin
                    legal    = 1'b1;
                    d.imm    = imm_i;
                    d.alu_op = alu_base(f3, 1'b0);
                end
            end
            OP_IMM32: begin
                d.instr_type = IT_I;
                d.rd         = instr[11:7];
                d.rs1        = instr[19:15];
                d.reg_write  = 1'b1;
                if (f3 == 3'b000) begin
                    legal    = RV64;
                    d.imm    = imm_i;
                    d.alu_op = ALU_ADD | ALU_WORD;
                end else begin
                    legal    = RV64 && ((f3 == 3'b001 && f7 == 7'b0000000) ||
                               (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)));
                    d.shamt  = {1'b0, instr[24:20]};
                    d.imm    = {59'd0, instr[24:20]};
                    d.alu_op = alu_base(f3, instr[30]) | ALU_WORD;
                end
            end
            OP_OP, OP_OP32: begin
                d.instr_type = IT_R;
                d.rd         = instr[11:7];
                d.rs1        = instr[19:15];
                d.rs2        = instr[24:20];
                d.reg_write  = 1'b1;
                if (f7 == 7'b0000001) begin
                    d.alu_op = alu_mul(f3);
                    legal    = M_OK && ((opcode == OP_OP) || f3 == 3'b000 || f3[2]);
                end else if (f7 == 7'b0000000) begin
                    d.alu_op = alu_base(f3, 1'b0);
                    legal    = (opcode == OP_OP) || f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101;
                end else begin
                    d.alu_op = alu_base(f3, 1'b1);
                    legal    = (f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101);
                end
                if (opcode == OP_OP32) begin
                    legal    = legal && RV64;
                    d.alu_op = d.alu_op | ALU_WORD;
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            d         = '0;
            d.illegal = 1'b1;
        end
        if (d.rd == 5'd0) d.reg_write = 1'b0;
        d.pc            = '0;
        d.pc[XLEN-1:0]  = pc;
    end

    assign entry = d;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes fetched instructions into a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when the buffer is empty.
// Backpressure: in_ready is a flop-derived (state != TWO); no combinational path from out_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int HAS_M = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] immediate,
    output logic [10:0]     alu_op,
    output logic [5:0]      shamt,
    output logic            reg_write,
    output logic [3:0]      instr_type,
    output logic [1:0]      mem_access,
    output logic [2:0]      mem_size,
    output logic            illegal,
    output logic [31:0]     decode_count
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t      state_q, state_d;
    entry_t      dec_entry, head_q, tail_q;
    logic        accept, issue;
    logic        load_head_dec, load_head_tail, load_tail;
    logic [31:0] decode_count_q;

    decode_logic #(.XLEN(XLEN), .HAS_M(HAS_M)) u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .entry (dec_entry)
    );

    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign issue     = out_valid && out_ready;

    // head_q is always the entry presented on the outputs; tail_q is the skid slot
    always_comb begin
        state_d        = state_q;
        load_head_dec  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d       = S_ONE;
                        load_head_dec = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && issue) begin
                        load_head_dec = 1'b1;
                    end else if (accept) begin
                        state_d   = S_TWO;
                        load_tail = 1'b1;
                    end else if (issue) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (issue) begin
                        state_d        = S_ONE;
                        load_head_tail = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head_dec)       head_q <= dec_entry;
            else if (load_head_tail) head_q <= tail_q;
            if (load_tail)           tail_q <= dec_entry;
        end
    end

    // Issue still counts in a flush cycle: the consumer has already taken it
    always_ff @(posedge clk) begin
        if (reset)      decode_count_q <= '0;
        else if (issue) decode_count_q <= decode_count_q + 32'd1;
    end

    assign decode_count = decode_count_q;
    assign out_pc       = head_q.pc[XLEN-1:0];
    assign rd           = head_q.rd;
    assign rs1          = head_q.rs1;
    assign rs2          = head_q.rs2;
    assign immediate    = head_q.imm[XLEN-1:0];
    assign alu_op       = head_q.alu_op;
    assign shamt        = head_q.shamt;
    assign reg_write    = head_q.reg_write;
    assign instr_type   = head_q.instr_type;
    assign mem_access   = head_q.mem_access;
    assign mem_size     = head_q.mem_size;
    assign illegal      = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV64+M and RV32-without-M instances share one input stream.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_reg_write, a_illegal;
    logic [63:0] a_out_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [10:0] a_alu;
    logic [5:0]  a_shamt;
    logic [3:0]  a_it;
    logic [1:0]  a_ma;
    logic [2:0]  a_ms;
    logic [31:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_reg_write, b_illegal;
    logic [31:0] b_out_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [10:0] b_alu;
    logic [5:0]  b_shamt;
    logic [3:0]  b_it;
    logic [1:0]  b_ma;
    logic [2:0]  b_ms;
    logic [31:0] b_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .HAS_M(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
        .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .immediate(a_imm), .alu_op(a_alu),
        .shamt(a_shamt), .reg_write(a_reg_write), .instr_type(a_it),
        .mem_access(a_ma), .mem_size(a_ms), .illegal(a_illegal), .decode_count(a_cnt)
    );

    decode_stage #(.XLEN(32), .HAS_M(0)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .immediate(b_imm), .alu_op(b_alu),
        .shamt(b_shamt), .reg_write(b_reg_write), .instr_type(b_it),
        .mem_access(b_ma), .mem_size(b_ms), .illegal(b_illegal), .decode_count(b_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [10:0] alu;
        logic        rw;
        logic [1:0]  ma;
        logic [2:0]  ms;
        logic [3:0]  it;
        logic [5:0]  sh;
        logic        ill32;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        //            instr         ill rd  rs1 rs2 imm                     alu                  rw ma        ms     it     sh  ill32
        vecs[0]  = '{32'h00500093, 0, 1,  0,  0, 64'd5,                  ALU_ADD,             1, MA_NONE,  MS_NONE, IT_I,  0,  0};
        vecs[1]  = '{32'h0010009B, 0, 1,  0,  0, 64'd1,                  ALU_ADD | ALU_WORD,  1, MA_NONE,  MS_NONE, IT_I,  0,  1};
        vecs[2]  = '{32'h022081B3, 0, 3,  1,  2, 64'd0,                  ALU_MUL,             1, MA_NONE,  MS_NONE, IT_R,  0,  1};
        vecs[3]  = '{32'h00813283, 0, 5,  2,  0, 64'd8,                  ALU_ADD,             1, MA_READ,  MS_D,    IT_I,  0,  1};
        vecs[4]  = '{32'hFFF3C303, 0, 6,  7,  0, 64'hFFFF_FFFF_FFFF_FFFF, ALU_ADD,            1, MA_READ,  MS_BU,   IT_I,  0,  0};
        vecs[5]  = '{32'hFE512E23, 0, 0,  2,  5, 64'hFFFF_FFFF_FFFF_FFFC, ALU_ADD,            0, MA_WRITE, MS_W,    IT_S,  0,  0};
        vecs[6]  = '{32'hFE208CE3, 0, 0,  1,  2, 64'hFFFF_FFFF_FFFF_FFF8, ALU_BEQ,            0, MA_NONE,  MS_NONE, IT_SB, 0,  0};
        vecs[7]  = '{32'h80000537, 0, 10, 0,  0, 64'hFFFF_FFFF_8000_0000, ALU_LUI,            1, MA_NONE,  MS_NONE, IT_U,  0,  0};
        vecs[8]  = '{32'h0010006F, 0, 0,  0,  0, 64'd2048,               ALU_ADD,             0, MA_NONE,  MS_NONE, IT_UJ, 0,  0};
        vecs[9]  = '{32'h000280E7, 0, 1,  5,  0, 64'd0,                  ALU_ADD,             1, MA_NONE,  MS_NONE, IT_I,  0,  0};
        vecs[10] = '{32'h02109093, 0, 1,  1,  0, 64'd33,                 ALU_SLL,             1, MA_NONE,  MS_NONE, IT_I,  33, 1};
        vecs[11] = '{32'h4041D113, 0, 2,  3,  0, 64'd4,                  ALU_SRA,             1, MA_NONE,  MS_NONE, IT_I,  4,  0};
        vecs[12] = '{32'h00000000, 1, 0,  0,  0, 64'd0,                  ALU_NONE,            0, MA_NONE,  MS_NONE, IT_NONE, 0, 1};
        vecs[13] = '{32'h04208133, 1, 0,  0,  0, 64'd0,                  ALU_NONE,            0, MA_NONE,  MS_NONE, IT_NONE, 0, 1};
        vecs[14] = '{32'h402081B3, 0, 3,  1,  2, 64'd0,                  ALU_SUB,             1, MA_NONE,  MS_NONE, IT_R,  0,  0};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 64'd0);
        step(); step();
        chk("rst.out_valid", a_out_valid, 0);
        chk("rst.in_ready",  a_in_ready, 1);
        chk("rst.count",     a_cnt, 0);
        chk("rst.fields",    {a_rd, a_imm, a_alu, a_reg_write, a_it, a_ma, a_ms, a_illegal}, 0);
        chk("rst32.out_valid", b_out_valid, 0);
        reset = 1'b0;

        // Streaming table: one vector per cycle, each checked one cycle after its accept
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].instr, 64'h1000 + 64'(i * 4));
            step();
            chk($sformatf("v%0d.out_valid", i), a_out_valid, 1);
            chk($sformatf("v%0d.out_pc", i),    a_out_pc, 64'h1000 + 64'(i * 4));
            chk($sformatf("v%0d.illegal", i),   a_illegal, vecs[i].ill);
            chk($sformatf("v%0d.rd", i),        a_rd, vecs[i].rd);
            chk($sformatf("v%0d.rs1", i),       a_rs1, vecs[i].rs1);
            chk($sformatf("v%0d.rs2", i),       a_rs2, vecs[i].rs2);
            chk($sformatf("v%0d.imm", i),       a_imm, vecs[i].imm);
            chk($sformatf("v%0d.alu_op", i),    a_alu, vecs[i].alu);
            chk($sformatf("v%0d.reg_write", i), a_reg_write, vecs[i].rw);
            chk($sformatf("v%0d.mem_access", i), a_ma, vecs[i].ma);
            chk($sformatf("v%0d.mem_size", i),  a_ms, vecs[i].ms);
            chk($sformatf("v%0d.instr_type", i), a_it, vecs[i].it);
            chk($sformatf("v%0d.shamt", i),     a_shamt, vecs[i].sh);
            chk($sformatf("v%0d.rv32.out_valid", i), b_out_valid, 1);
            chk($sformatf("v%0d.rv32.out_pc", i),    b_out_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d.rv32.illegal", i),   b_illegal, vecs[i].ill32);
            chk($sformatf("v%0d.rv32.reg_write", i), b_reg_write, vecs[i].ill32 ? 1'b0 : vecs[i].rw);
            if (!vecs[i].ill32) begin
                chk($sformatf("v%0d.rv32.imm", i),   b_imm, vecs[i].imm[31:0]);
                chk($sformatf("v%0d.rv32.fields", i), {b_rd, b_rs1, b_rs2, b_alu, b_shamt, b_it, b_ma, b_ms},
                    {vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].alu, vecs[i].sh, vecs[i].it, vecs[i].ma, vecs[i].ms});
            end else begin
                chk($sformatf("v%0d.rv32.alu_op", i), b_alu, ALU_NONE);
            end
        end
        drive(1'b0, 32'd0, 64'd0);
        step();
        chk("drain.out_valid", a_out_valid, 0);
        chk("drain.count",     a_cnt, 15);
        chk("drain.rv32.count", b_cnt, 15);

        // Backpressure: hold out_ready low for 3 cycles with in_valid continuously high
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h200);
        step();
        chk("bp.in_ready1", a_in_ready, 1);
        drive(1'b1, 32'h00200113, 64'h204);
        step();
        chk("bp.in_ready2", a_in_ready, 0);
        chk("bp.rv32.in_ready2", b_in_ready, 0);
        drive(1'b1, 32'h00300193, 64'h208);
        step();
        chk("bp.hold.pc", a_out_pc, 64'h200);
        chk("bp.hold.rd", a_rd, 1);
        chk("bp.hold.in_ready", a_in_ready, 0);
        drive(1'b0, 32'd0, 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp.rel1.pc", a_out_pc, 64'h204);
        chk("bp.rel1.rd", a_rd, 2);
        chk("bp.rel1.in_ready", a_in_ready, 1);
        step();
        chk("bp.rel2.out_valid", a_out_valid, 0);
        chk("bp.rel2.count", a_cnt, 17);

        // Flush while full; a same-cycle accept must be dropped
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h300);
        step();
        drive(1'b1, 32'h00200113, 64'h304);
        step();
        chk("fl.full", a_in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 32'h00300193, 64'h308);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0);
        chk("fl.out_valid", a_out_valid, 0);
        chk("fl.in_ready",  a_in_ready, 1);
        chk("fl.count",     a_cnt, 17);
        step();
        chk("fl.no_accept", a_out_valid, 0);

        // Flush coinciding with an issue: issue counts, buffer still empties
        drive(1'b1, 32'h00100093, 64'h400);
        step();
        drive(1'b0, 32'd0, 64'd0);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fli.count",     a_cnt, 18);
        chk("fli.out_valid", a_out_valid, 0);

        // Reset while full, together with flush
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h500);
        step();
        drive(1'b1, 32'h00200113, 64'h504);
        step();
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0);
        chk("mrst.out_valid", a_out_valid, 0);
        chk("mrst.in_ready",  a_in_ready, 1);
        chk("mrst.count",     a_cnt, 0);
        chk("mrst.rd",        a_rd, 0);
        step();
        chk("mrst.stay_empty", a_out_valid, 0);

        // Counter wrap from all-ones
        force dut.decode_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.decode_count_q;
        chk("wrap.preload", a_cnt, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        drive(1'b1, 32'h00500093, 64'h600);
        step();
        drive(1'b0, 32'd0, 64'd0);
        step();
        chk("wrap.count", a_cnt, 0);
        chk("wrap.rv32.count", b_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
